// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width, depth and Gray/binary helpers.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 1 << ADDRSIZE;
  localparam int PTRW     = ADDRSIZE + 1;

  typedef logic [PTRW-1:0] ptr_t;

  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PTRW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus that changes at most one bit per source cycle.
// Synchronous active-high reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d;
      q2_q <= q1_q;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/level/almost-full/overflow controller of the async FIFO.
// The Gray/binary helpers are sized from fifo_pkg::ADDRSIZE, so ADDRSIZE must match it.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = fifo_pkg::ADDRSIZE,
  parameter int AFULL_MARGIN = 2
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              win,
  input  logic [ADDRSIZE:0] rptr_gray,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0] wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDRSIZE:0] wlevel,
  output logic              woverflow
);

  localparam int W_DEPTH = 1 << ADDRSIZE;

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wgray_q, wgray_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              wafull_q, wafull_d;
  logic              wovf_q, wovf_d;
  logic [ADDRSIZE:0] rq2;
  logic [ADDRSIZE:0] rq2_bin;
  logic              wacc;

  sync_2ff #(
    .WIDTH (ADDRSIZE + 1)
  ) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (rptr_gray),
    .q   (rq2)
  );

  always_comb begin
    wacc     = win & ~wfull_q;
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wacc};
    wgray_d  = bin2gray(wbin_d);
    rq2_bin  = gray2bin(rq2);
    wlevel_d = wbin_d - rq2_bin;
    // Full when the write pointer has lapped the read pointer exactly once.
    wfull_d  = (wgray_d == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]});
    wafull_d = (int'(wlevel_d) >= (W_DEPTH - AFULL_MARGIN));
    wovf_d   = wovf_q | (win & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against an occupancy-count model.
module tb_fifo_wptr_full;

  logic       wclk;
  logic       wrst;
  logic       win;
  logic [4:0] rptr_gray;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wptr_full #(
    .ADDRSIZE     (4),
    .AFULL_MARGIN (2)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .win          (win),
    .rptr_gray    (rptr_gray),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  // Inverse Gray by search: whichever 5-bit count encodes to g.
  function automatic int from_gray(input int g);
    for (int b = 0; b < 32; b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  // Model: count of accepted writes (mod 32) and the read count seen two edges late.
  int  m_wcnt, m_level, m_seen1, m_seen2;
  bit  m_full, m_afull, m_ovf, m_valid;

  always @(posedge wclk) begin
    if (wrst) begin
      m_wcnt = 0; m_level = 0; m_seen1 = 0; m_seen2 = 0;
      m_full = 0; m_afull = 0; m_ovf = 0; m_valid = 1;
    end else if (m_valid) begin
      if (win && m_full) m_ovf = 1;
      if (win && !m_full) m_wcnt = (m_wcnt + 1) % 32;
      m_level = (m_wcnt - m_seen2 + 32) % 32;
      m_full  = (m_level == 16);
      m_afull = (m_level >= 14);
      m_seen2 = m_seen1;
      m_seen1 = from_gray(int'(rptr_gray));
    end
  end

  always @(negedge wclk) begin
    if (m_valid) begin
      check("waddr",        int'(waddr),        m_wcnt % 16);
      check("wptr_gray",    int'(wptr_gray),    to_gray(m_wcnt));
      check("wlevel",       int'(wlevel),       m_level);
      check("wfull",        int'(wfull),        int'(m_full));
      check("walmost_full", int'(walmost_full), int'(m_afull));
      check("woverflow",    int'(woverflow),    int'(m_ovf));
    end
  end

  int rb = 0;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_rb(input int b);
    rb = b % 32;
    rptr_gray = 5'(to_gray(rb));
  endtask

  task automatic advance_rb_to(input int b);
    while (rb != (b % 32)) begin
      set_rb(rb + 1);
      tick();
    end
  endtask

  initial begin
    wrst = 1'b1; win = 1'b0; rptr_gray = '0;
    m_valid = 0;
    tick();
    tick();
    wrst = 1'b0;
    check("reset_level", int'(wlevel), 0);
    check("reset_full",  int'(wfull),  0);

    // Fill
    win = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_waddr", int'(waddr), i);
      tick();
      if (i == 12) check("afull_at13", int'(walmost_full), 0);
      if (i == 13) check("afull_at14", int'(walmost_full), 1);
    end
    check("full_waddr", int'(waddr),     0);
    check("full_gray",  int'(wptr_gray), 5'b11000);
    check("full_level", int'(wlevel),    16);
    check("full_flag",  int'(wfull),     1);

    // Overflow
    tick();
    check("ovf_set",    int'(woverflow), 1);
    tick();
    tick();
    check("ovf_waddr",  int'(waddr),     0);
    check("ovf_gray",   int'(wptr_gray), 5'b11000);
    check("ovf_level",  int'(wlevel),    16);
    win = 1'b0;

    // Drain by one
    set_rb(1);
    tick();
    check("drain_e",    int'(wfull), 1);
    tick();
    check("drain_e1",   int'(wfull), 1);
    tick();
    check("drain_e2",   int'(wfull),  0);
    check("drain_lvl",  int'(wlevel), 15);
    check("ovf_sticky", int'(woverflow), 1);

    // Wrap: read pointer to 16, then write 16 entries
    advance_rb_to(16);
    tick(); tick(); tick();
    check("wrap_empty", int'(wlevel), 0);
    win = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    win = 1'b0;
    check("wrap_gray",  int'(wptr_gray), 0);
    check("wrap_waddr", int'(waddr),     0);
    check("wrap_full",  int'(wfull),     1);

    // One read then one write refills
    set_rb(17);
    tick(); tick(); tick();
    check("refill_pre", int'(wfull), 0);
    win = 1'b1;
    tick();
    win = 1'b0;
    check("refill_full", int'(wfull), 1);

    // Simultaneous write and read advance at level 15
    set_rb(18);
    tick(); tick(); tick();
    check("sim_pre", int'(wlevel), 15);
    win = 1'b1;
    set_rb(19);
    tick();
    win = 1'b0;
    check("sim_lvl0",  int'(wlevel), 16);
    check("sim_full0", int'(wfull),  1);
    tick();
    tick();
    check("sim_lvl2",  int'(wlevel), 15);
    check("sim_full2", int'(wfull),  0);

    // Reset mid-operation at level 9
    advance_rb_to(25);
    tick(); tick(); tick();
    check("mid_lvl9", int'(wlevel), 9);
    wrst = 1'b1; win = 1'b1;
    set_rb(0);
    tick();
    wrst = 1'b0; win = 1'b0;
    check("rst_waddr", int'(waddr),        0);
    check("rst_gray",  int'(wptr_gray),    0);
    check("rst_level", int'(wlevel),       0);
    check("rst_full",  int'(wfull),        0);
    check("rst_afull", int'(walmost_full), 0);
    check("rst_ovf",   int'(woverflow),    0);
    tick();
    check("rst_nowr",  int'(wlevel), 0);

    // Random traffic with phases biased toward filling or draining
    for (int blk = 0; blk < 20; blk++) begin
      int wp, rp;
      wp = (blk % 2 == 0) ? 80 : 30;
      rp = (blk % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 150; c++) begin
        win = ($urandom_range(0, 99) < wp);
        if (($urandom_range(0, 99) < rp) && (((m_wcnt - rb + 32) % 32) != 0))
          set_rb(rb + 1);
        tick();
      end
    end
    win = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
